spi_cmd_sequencer: RTL and testbench

SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

---
 rtl/spi_cmd_sequencer_if.sv | 19 +
 rtl/spi_cmd_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_sequencer_if.sv
// Command stream between the sequencer and the downstream SPI shifter.
// The master side drives cmd_data/cmd_valid; the slave side returns cmd_ready.
interface spi_cmd_sequencer_if;
  logic [23:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Table-driven SPI command sequencer: streams table entries 0..num_entries-1 to a shifter.
// Defining SPI_SEQ_GAP_EN adds gap_cycles and a GAP state between commands.
module spi_cmd_sequencer #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tbl_we,
  input  logic [AW-1:0]       tbl_addr,
  input  logic [23:0]         tbl_wdata,
  input  logic                start,
  input  logic [AW:0]         num_entries,
  input  logic                abort,
`ifdef SPI_SEQ_GAP_EN
  input  logic [7:0]          gap_cycles,
`endif
  spi_cmd_sequencer_if.master cmd,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [AW:0]         idx
);

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneW   = (AW+1)'(1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StIssue = 3'd2,
`ifdef SPI_SEQ_GAP_EN
    StGap   = 3'd3,
`endif
    StDone  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] idx_q, idx_d;
  logic [AW:0] idx_inc;
  logic [23:0] cmd_data_q, cmd_data_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef SPI_SEQ_GAP_EN
  logic [7:0]  gap_len_q, gap_len_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
`endif

  logic [23:0] mem_q [DEPTH];
  logic [23:0] rdata_q;

  // Single-port table: writes only outside a run, reads only in FETCH, so they never collide.
  always_ff @(posedge clk) begin
    if (tbl_we && !busy_q) begin
      mem_q[tbl_addr] <= tbl_wdata;
    end
    if (state_q == StFetch) begin
      rdata_q <= mem_q[idx_q[AW-1:0]];
    end
  end

  assign idx_inc = idx_q + OneW;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = cmd_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef SPI_SEQ_GAP_EN
    gap_len_d   = gap_len_q;
    gap_cnt_d   = gap_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          if (num_entries == '0) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = StDone;
          end else if (num_entries > DepthW) begin
            err_d = 1'b1;
          end else begin
            count_d = num_entries;
            idx_d   = '0;
            state_d = StFetch;
`ifdef SPI_SEQ_GAP_EN
            gap_len_d = gap_cycles;
`endif
          end
        end
      end
      StFetch: begin
        state_d = StIssue;
      end
      StIssue: begin
        // First ISSUE cycle moves the RAM read data into the output register.
        if (!cmd_valid_q) begin
          cmd_data_d  = rdata_q;
          cmd_valid_d = 1'b1;
        end else if (cmd.cmd_ready) begin
          cmd_valid_d = 1'b0;
          idx_d       = idx_inc;
          if (idx_inc == count_q) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
`ifdef SPI_SEQ_GAP_EN
            if (gap_len_q == 8'd0) begin
              state_d = StFetch;
            end else begin
              gap_cnt_d = gap_len_q;
              state_d   = StGap;
            end
`else
            state_d = StFetch;
`endif
          end
        end
      end
`ifdef SPI_SEQ_GAP_EN
      StGap: begin
        if (gap_cnt_q <= 8'd1) begin
          state_d = StFetch;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d     = StIdle;
        cmd_valid_d = 1'b0;
      end
    endcase

    // Abort wins over any same-cycle handshake; idx and cmd_data keep their values.
    if (abort && busy_q) begin
      state_d     = StIdle;
      cmd_valid_d = 1'b0;
      cmd_data_d  = cmd_data_q;
      idx_d       = idx_q;
      done_d      = 1'b0;
    end

`ifdef SPI_SEQ_GAP_EN
    busy_d = (state_d == StFetch) || (state_d == StIssue) || (state_d == StGap);
`else
    busy_d = (state_d == StFetch) || (state_d == StIssue);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      idx_q       <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef SPI_SEQ_GAP_EN
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef SPI_SEQ_GAP_EN
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

  assign cmd.cmd_data  = cmd_data_q;
  assign cmd.cmd_valid = cmd_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign idx           = idx_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: stimulus pushes expected words, a monitor pops them.
module tb_spi_cmd_sequencer;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          tbl_we;
  logic [AW-1:0] tbl_addr;
  logic [23:0]   tbl_wdata;
  logic          start;
  logic [AW:0]   num_entries;
  logic          abort;
  logic          busy, done, err;
  logic [AW:0]   idx;
`ifdef SPI_SEQ_GAP_EN
  logic [7:0]    gap_cycles;
`endif

  spi_cmd_sequencer_if cmd_if ();

  spi_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_wdata   (tbl_wdata),
    .start       (start),
    .num_entries (num_entries),
    .abort       (abort),
`ifdef SPI_SEQ_GAP_EN
    .gap_cycles  (gap_cycles),
`endif
    .cmd         (cmd_if.master),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .idx         (idx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: handshakes are judged on the falling edge, half a cycle before the sampling edge.
  logic        prev_pend = 1'b0;
  logic [23:0] prev_data = '0;
  always @(negedge clk) begin
    if (prev_pend) begin
      check("stall_valid", 32'(cmd_if.cmd_valid), 32'd1);
      check("stall_data", 32'(cmd_if.cmd_data), 32'(prev_data));
    end
    if (!reset && !abort && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", 32'(cmd_if.cmd_data), 32'hFFFF_FFFF);
      end else begin
        check("cmd_data", 32'(cmd_if.cmd_data), 32'(exp_q.pop_front()));
      end
    end
    if (!reset && done) done_cnt++;
    prev_pend = !reset && !abort && cmd_if.cmd_valid && !cmd_if.cmd_ready;
    prev_data = cmd_if.cmd_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [23:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic go(input logic [AW:0] n);
    start = 1'b1; num_entries = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!cmd_if.cmd_valid && n < 60) begin tick(); n++; end
    if (!cmd_if.cmd_valid) check(name, 32'(cmd_if.cmd_valid), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin tick(); n++; end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic push3;
    exp_q.push_back(24'h00_1401);
    exp_q.push_back(24'h00_2502);
    exp_q.push_back(24'h01_0003);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    start = 1'b0; num_entries = '0; abort = 1'b0; cmd_if.cmd_ready = 1'b0;
`ifdef SPI_SEQ_GAP_EN
    gap_cycles = 8'd0;
`endif
    repeat (3) tick();
    check("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("rst_data", 32'(cmd_if.cmd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    reset = 1'b0;
    tick();

    wr(9'd0, 24'h00_1401);
    wr(9'd1, 24'h00_2502);
    wr(9'd2, 24'h01_0003);

    // Basic run with ready held high.
    d0 = done_cnt;
    push3();
    cmd_if.cmd_ready = 1'b1;
    go(10'd3);
    check("run_busy", 32'(busy), 32'd1);
    tick();
    check("valid_start+1", 32'(cmd_if.cmd_valid), 32'd0);
    tick();
    check("valid_start+2", 32'(cmd_if.cmd_valid), 32'd1);
    check("first_data", 32'(cmd_if.cmd_data), 32'h00_1401);
    wait_done("run_done");
    check("run_idx", 32'(idx), 32'd3);
    tick(); tick();
    check("run_done_once", 32'(done_cnt - d0), 32'd1);
    check("run_busy_end", 32'(busy), 32'd0);

    // Back-pressure on entry 1 for 10 cycles.
    push3();
    cmd_if.cmd_ready = 1'b0;
    go(10'd3);
    wait_valid("stall_e0");
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    wait_valid("stall_e1");
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(cmd_if.cmd_valid), 32'd1);
      check("hold_data", 32'(cmd_if.cmd_data), 32'h00_2502);
      tick();
    end
    cmd_if.cmd_ready = 1'b1;
    wait_done("stall_done");
    check("stall_idx", 32'(idx), 32'd3);
    tick();

    // Zero-length run and out-of-range request.
    go(10'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    tick();
    check("zero_done_end", 32'(done), 32'd0);
    go(10'd513);
    check("over_err", 32'(err), 32'd1);
    check("over_busy", 32'(busy), 32'd0);
    tick();
    check("over_err_end", 32'(err), 32'd0);
    check("over_busy2", 32'(busy), 32'd0);

    // Abort during entry 1, together with a same-cycle ready.
    d0 = done_cnt;
    exp_q.push_back(24'h00_1401);
    cmd_if.cmd_ready = 1'b0;
    go(10'd3);
    wait_valid("abort_e0");
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    wait_valid("abort_e1");
    abort = 1'b1; cmd_if.cmd_ready = 1'b1;
    tick();
    abort = 1'b0; cmd_if.cmd_ready = 1'b0;
    check("abort_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_idx", 32'(idx), 32'd1);
    tick(); tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    push3();
    cmd_if.cmd_ready = 1'b1;
    go(10'd3);
    wait_done("rerun_done");
    check("rerun_idx", 32'(idx), 32'd3);
    tick();

    // Table write while busy must be dropped.
    exp_q.push_back(24'h00_1401);
    cmd_if.cmd_ready = 1'b0;
    go(10'd1);
    wr(9'd0, 24'hAB_CDEF);
    cmd_if.cmd_ready = 1'b1;
    wait_done("we_busy_done");
    tick();
    exp_q.push_back(24'h00_1401);
    go(10'd1);
    wait_done("we_busy_rerun");
    tick();

`ifdef SPI_SEQ_GAP_EN
    // Five GAP cycles plus FETCH and load before the next valid.
    exp_q.push_back(24'h00_1401);
    exp_q.push_back(24'h00_2502);
    gap_cycles = 8'd5;
    cmd_if.cmd_ready = 1'b1;
    go(10'd2);
    wait_valid("gap_e0");
    tick();
    for (int i = 0; i < 7; i++) begin
      check("gap_idle", 32'(cmd_if.cmd_valid), 32'd0);
      tick();
    end
    check("gap_valid", 32'(cmd_if.cmd_valid), 32'd1);
    wait_done("gap_done");
    gap_cycles = 8'd0;
    tick();
`endif

    // Reset mid-run, then the table must reproduce the original data.
    cmd_if.cmd_ready = 1'b0;
    go(10'd3);
    wait_valid("rst_run");
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("mid_rst_data", 32'(cmd_if.cmd_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_idx", 32'(idx), 32'd0);
    reset = 1'b0;
    tick();
    push3();
    cmd_if.cmd_ready = 1'b1;
    go(10'd3);
    wait_done("post_rst_done");
    check("post_rst_idx", 32'(idx), 32'd3);
    tick(); tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
